// File: rtl/multiplier_seq_n_bit_v_pkg.sv
// -----------------------------------------------------------------------------
// multiplier_seq_n_bit_v_pkg
// Shared definitions for the sequential shift-add multiplier:
//   - state_t          : controller state encoding
//   - MAX_PROD_W       : widest product the negate helper supports
//   - f_cond_negate    : two's-complement negate when i_neg is set; used both
//                        for operand magnitudes and for the final sign fix
// -----------------------------------------------------------------------------
package multiplier_seq_n_bit_v_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int MAX_PROD_W = 64;

   // Callers zero-extend into MAX_PROD_W and truncate the result back to their
   // own width; modular negation makes the low bits correct for any width.
   function automatic logic [MAX_PROD_W-1:0] f_cond_negate(
      input logic [MAX_PROD_W-1:0] i_val,
      input logic                  i_neg
   );
      return i_neg ? (-i_val) : i_val;
   endfunction

endpackage

// File: rtl/multiplier_seq_n_bit_v_adder.sv
// -----------------------------------------------------------------------------
// binary_n_bit_adder_v
// W-bit ripple adder with carry in/out; the single adder the multiplier iterates.
// Ports:
//   i_a, i_b  in  W   addends
//   i_cin     in  1   carry in
//   o_sum     out W   sum bits
//   o_cout    out 1   carry out (bit W of the sum)
// -----------------------------------------------------------------------------
module binary_n_bit_adder_v #(
   parameter int W = 4
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_cin,
   output logic [W-1:0] o_sum,
   output logic         o_cout
);

   assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};

endmodule

// File: rtl/multiplier_seq_n_bit_v.sv
// -----------------------------------------------------------------------------
// multiplier_seq_n_bit_v
// Sequential shift-add multiplier, W-bit operands, 2W-bit product, unsigned or
// two's-complement per request. One adder, W iterations, start/ack handshake.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | o_ready=1, waiting for i_start; operands loaded on accept
//   ST_BUSY | one add/shift per edge; r_cnt counts down to terminal 0
//   ST_DONE | o_valid=1, product held until i_ack
//
// Ports:
//   i_clk     in  1  clock, rising edge
//   i_rst     in  1  asynchronous active-high reset
//   i_start   in  1  request, accepted only while o_ready=1
//   i_signed  in  1  0 unsigned, 1 two's-complement (sampled with i_start)
//   i_a, i_b  in  W  multiplicand / multiplier
//   i_ack     in  1  result consumed, honoured only while o_valid=1
//   o_ready   out 1  idle
//   o_valid   out 1  product available
//   o_p_lo    out W  product [W-1:0]
//   o_p_hi    out W  product [2W-1:W]
// -----------------------------------------------------------------------------
module multiplier_seq_n_bit_v
   import multiplier_seq_n_bit_v_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_start,
   input  logic         i_signed,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_ack,
   output logic         o_ready,
   output logic         o_valid,
   output logic [W-1:0] o_p_lo,
   output logic [W-1:0] o_p_hi
);

   localparam int                 CNT_W    = $clog2(W);
   localparam int                 P_W      = 2 * W;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(W - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [W-1:0]     r_mcand;
   logic [W-1:0]     r_mplier;
   logic [P_W-1:0]   r_acc;
   logic             r_neg;
   logic [W-1:0]     r_p_lo;
   logic [W-1:0]     r_p_hi;

   logic             w_accept;
   logic             w_last;
   logic [W-1:0]     w_a_mag;
   logic [W-1:0]     w_b_mag;
   logic [W-1:0]     w_addend;
   logic [W-1:0]     w_sum;
   logic             w_cout;
   logic [P_W-1:0]   w_acc_nxt;
   logic [P_W-1:0]   w_prod;

   // Magnitude of -2^(W-1) is 2^(W-1), which still fits in W unsigned bits.
   assign w_a_mag = W'(f_cond_negate(MAX_PROD_W'(i_a), i_signed & i_a[W-1]));
   assign w_b_mag = W'(f_cond_negate(MAX_PROD_W'(i_b), i_signed & i_b[W-1]));

   assign w_addend = r_mplier[0] ? r_mcand : '0;

   binary_n_bit_adder_v #(.W(W)) u_adder (
      .i_a    (r_acc[P_W-1:W]),
      .i_b    (w_addend),
      .i_cin  (1'b0),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   // Carry re-enters at the top so the W+1-bit partial sum is never lost.
   assign w_acc_nxt = {w_cout, w_sum, r_acc[W-1:1]};

   // Final iteration's result goes straight to the outputs, so the sign fix
   // works on the not-yet-registered accumulator.
   assign w_prod = P_W'(f_cond_negate(MAX_PROD_W'(w_acc_nxt), r_neg));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      o_ready     = 1'b0;
      o_valid     = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            o_ready = 1'b1;
            if (i_start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (r_cnt == '0) begin
               w_last      = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            o_valid = 1'b1;
            if (i_ack) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_neg    <= 1'b0;
         r_p_lo   <= '0;
         r_p_hi   <= '0;
      end else begin
         if (w_accept) begin
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_neg    <= i_signed & (i_a[W-1] ^ i_b[W-1]);
            r_cnt    <= CNT_LAST;
            r_acc    <= '0;
         end else if (r_state == ST_BUSY) begin
            r_acc    <= w_acc_nxt;
            r_mplier <= r_mplier >> 1;
            if (r_cnt != '0) begin
               r_cnt <= r_cnt - CNT_W'(1);
            end
         end
         if (w_last) begin
            r_p_hi <= w_prod[P_W-1:W];
            r_p_lo <= w_prod[W-1:0];
         end
      end
   end

   assign o_p_lo = r_p_lo;
   assign o_p_hi = r_p_hi;

endmodule

// File: tb/tb_multiplier_seq_n_bit_v.sv
module tb_multiplier_seq_n_bit_v;

   logic clk;
   logic rst4;
   logic rst_g;
   int   n_checks;
   int   n_errors;
   bit   gen_go;
   bit   gen_done [2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   // Reference: interpret operands per mode, multiply as integers, wrap to 2w bits.
   function automatic longint ref_prod(input longint a, input longint b, input bit sgn, input int w);
      longint sa;
      longint sb;
      longint p;
      sa = a;
      sb = b;
      if (sgn) begin
         if (a >= (longint'(1) << (w - 1))) sa = a - (longint'(1) << w);
         if (b >= (longint'(1) << (w - 1))) sb = b - (longint'(1) << w);
      end
      p = sa * sb;
      return p & ((longint'(1) << (2 * w)) - 1);
   endfunction

   // ---------------- W=4 instance: directed + exhaustive ----------------
   logic       s4_start, s4_signed, s4_ack, s4_ready, s4_valid;
   logic [3:0] s4_a, s4_b, s4_lo, s4_hi;
   logic [7:0] exp_q4 [$];
   bit         seen4;

   multiplier_seq_n_bit_v #(.W(4)) u_dut4 (
      .i_clk    (clk),
      .i_rst    (rst4),
      .i_start  (s4_start),
      .i_signed (s4_signed),
      .i_a      (s4_a),
      .i_b      (s4_b),
      .i_ack    (s4_ack),
      .o_ready  (s4_ready),
      .o_valid  (s4_valid),
      .o_p_lo   (s4_lo),
      .o_p_hi   (s4_hi)
   );

   always @(negedge clk) begin
      if (s4_valid && !seen4) begin
         seen4 = 1'b1;
         if (exp_q4.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_valid4: got product %0h with no request pending", {s4_hi, s4_lo});
         end else begin
            check("prod4", {s4_hi, s4_lo}, exp_q4.pop_front());
         end
      end
      if (!s4_valid) seen4 = 1'b0;
   end

   task automatic do_op4(input logic [3:0] a, input logic [3:0] b, input logic sgn,
                         input int ack_delay, input bit poke_busy, input bit start_with_ack);
      int         t;
      logic [7:0] e;
      e = 8'(ref_prod(longint'(a), longint'(b), sgn, 4));
      t = 0;
      while (!s4_ready && t < 50) begin
         @(posedge clk); #1; t++;
      end
      check("ready_before4", s4_ready, 1);
      s4_a = a; s4_b = b; s4_signed = sgn; s4_start = 1'b1;
      exp_q4.push_back(e);
      @(posedge clk); #1;
      s4_start  = 1'b0;
      s4_a      = 4'($urandom);
      s4_b      = 4'($urandom);
      s4_signed = 1'($urandom);
      check("busy_ready4", s4_ready, 0);
      t = 0;
      while (!s4_valid && t < 20) begin
         s4_start = poke_busy && (t == 1);
         s4_ack   = poke_busy && (t == 2);
         @(posedge clk); #1; t++;
      end
      s4_start = 1'b0;
      s4_ack   = 1'b0;
      check("latency4", t, 4);
      for (int i = 0; i < ack_delay; i++) begin
         @(negedge clk);
         check("hold_valid4", s4_valid, 1);
         check("hold_prod4", {s4_hi, s4_lo}, e);
         check("hold_ready4", s4_ready, 0);
         @(posedge clk); #1;
      end
      s4_ack   = 1'b1;
      s4_start = start_with_ack;
      @(posedge clk); #1;
      s4_ack   = 1'b0;
      s4_start = 1'b0;
      check("ack_ready4", s4_ready, 1);
      check("ack_valid4", s4_valid, 0);
      check("ack_keep4", {s4_hi, s4_lo}, e);
      if (start_with_ack) begin
         @(posedge clk); #1;
         check("start_dropped4", s4_ready, 1);
      end
   endtask

   // ---------------- W=8 and W=5 instances: random sweep ----------------
   for (genvar g = 0; g < 2; g++) begin : g_rand
      localparam int GW = (g == 0) ? 8 : 5;
      logic            st, sg, ak, rdy, vld;
      logic [GW-1:0]   ga, gb, lo, hi;
      logic [2*GW-1:0] q [$];
      bit              seen;

      multiplier_seq_n_bit_v #(.W(GW)) u_dut (
         .i_clk    (clk),
         .i_rst    (rst_g),
         .i_start  (st),
         .i_signed (sg),
         .i_a      (ga),
         .i_b      (gb),
         .i_ack    (ak),
         .o_ready  (rdy),
         .o_valid  (vld),
         .o_p_lo   (lo),
         .o_p_hi   (hi)
      );

      always @(negedge clk) begin
         if (vld && !seen) begin
            seen = 1'b1;
            if (q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_valid_w%0d: got product %0h with no request pending", GW, {hi, lo});
            end else begin
               check($sformatf("prod_w%0d", GW), {hi, lo}, q.pop_front());
            end
         end
         if (!vld) seen = 1'b0;
      end

      initial begin
         int t;
         st = 1'b0; sg = 1'b0; ak = 1'b0; ga = '0; gb = '0;
         gen_done[g] = 1'b0;
         wait (gen_go);
         @(posedge clk); #1;
         for (int n = 0; n < 60; n++) begin
            t = 0;
            while (!rdy && t < 50) begin
               @(posedge clk); #1; t++;
            end
            check($sformatf("ready_w%0d", GW), rdy, 1);
            ga = GW'($urandom);
            gb = GW'($urandom);
            sg = 1'($urandom);
            if (n % 5 == 0) ga = {1'b1, {(GW-1){1'b0}}};
            if (n % 7 == 0) gb = '1;
            if (n % 10 == 0) gb = {1'b1, {(GW-1){1'b0}}};
            q.push_back((2*GW)'(ref_prod(longint'(ga), longint'(gb), sg, GW)));
            st = 1'b1;
            @(posedge clk); #1;
            st = 1'b0;
            ga = GW'($urandom);
            gb = GW'($urandom);
            t = 0;
            while (!vld && t < 3 * GW) begin
               @(posedge clk); #1; t++;
            end
            check($sformatf("latency_w%0d", GW), t, GW);
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk); #1;
            end
            ak = 1'b1;
            @(posedge clk); #1;
            ak = 1'b0;
         end
         @(posedge clk); #1;
         check($sformatf("queue_empty_w%0d", GW), q.size(), 0);
         gen_done[g] = 1'b1;
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      int t;
      int vcnt;
      n_checks = 0;
      n_errors = 0;
      gen_go   = 1'b0;
      rst4 = 1'b1; rst_g = 1'b1;
      s4_start = 1'b0; s4_signed = 1'b0; s4_ack = 1'b0; s4_a = '0; s4_b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready4", s4_ready, 1);
      check("rst_valid4", s4_valid, 0);
      check("rst_prod4", {s4_hi, s4_lo}, 0);
      @(negedge clk);
      rst4 = 1'b0; rst_g = 1'b0;
      @(posedge clk); #1;

      // Directed vectors
      do_op4(4'd13, 4'd11, 1'b0, 0, 1'b0, 1'b0);
      do_op4(4'd15, 4'd15, 1'b0, 0, 1'b0, 1'b0);
      do_op4(4'hF,  4'hF,  1'b1, 0, 1'b0, 1'b0);
      do_op4(4'hD,  4'd5,  1'b1, 0, 1'b0, 1'b0);
      do_op4(4'h8,  4'h8,  1'b1, 0, 1'b0, 1'b0);
      // Handshake: held result, start/ack pokes while busy, start together with ack
      do_op4(4'd9,  4'd7,  1'b0, 5, 1'b1, 1'b1);
      do_op4(4'h8,  4'd3,  1'b1, 2, 1'b1, 1'b0);

      // Reset mid-operation
      do_op4(4'd13, 4'd11, 1'b0, 0, 1'b0, 1'b0);
      s4_a = 4'd7; s4_b = 4'd3; s4_signed = 1'b0; s4_start = 1'b1;
      @(posedge clk); #1;
      s4_start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst4 = 1'b1;
      #1;
      check("midrst_valid4", s4_valid, 0);
      check("midrst_ready4", s4_ready, 1);
      check("midrst_prod4", {s4_hi, s4_lo}, 0);
      @(negedge clk);
      rst4 = 1'b0;
      vcnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (s4_valid) vcnt++;
      end
      check("midrst_no_valid4", vcnt, 0);
      @(posedge clk); #1;

      // Exhaustive sweep
      for (int s = 0; s < 2; s++)
         for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
               do_op4(4'(a), 4'(b), 1'(s), 0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("queue_empty4", exp_q4.size(), 0);

      gen_go = 1'b1;
      t = 0;
      while (!(gen_done[0] && gen_done[1]) && t < 20000) begin
         @(posedge clk); t++;
      end
      check("rand_complete", {62'd0, gen_done[1], gen_done[0]}, 2'b11);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
